// File: rtl/condlogic_pred_if.sv
// condlogic_pred_if: decoder-side bundle for the conditional-execution unit.
// The decoder (master) drives instruction, flag and IT inputs; the unit
// (slave) returns the gated strobes, the condition result, the flags and
// the IT-active indication. clk and reset are kept as plain module ports.
interface condlogic_pred_if #(
  parameter int CTRL_W = 3,
  parameter int IT_MAX = 4,
  parameter int LEN_W  = $clog2(IT_MAX + 1)
);
  logic              en;
  logic              flush;
  logic [3:0]        Cond;
  logic [3:0]        ALUFlags;
  logic [1:0]        FlagW;
  logic [CTRL_W-1:0] Ctrl;
  logic              ITStart;
  logic [3:0]        ITCond;
  logic [LEN_W-1:0]  ITLen;
  logic [IT_MAX-1:0] ITPattern;
  logic [CTRL_W-1:0] CtrlOut;
  logic              CondEx;
  logic [3:0]        Flags;
  logic              InIT;

  modport master (
    output en, flush, Cond, ALUFlags, FlagW, Ctrl,
    output ITStart, ITCond, ITLen, ITPattern,
    input  CtrlOut, CondEx, Flags, InIT
  );

  modport slave (
    input  en, flush, Cond, ALUFlags, FlagW, Ctrl,
    input  ITStart, ITCond, ITLen, ITPattern,
    output CtrlOut, CondEx, Flags, InIT
  );
endinterface

// File: rtl/condlogic_pred.sv
// condlogic_pred: conditional-execution unit for the ARM-subset core.
// Holds NZCV with split write enables, evaluates the 16 condition codes,
// gates and registers CTRL_W control strobes, and optionally predicates up
// to IT_MAX following instructions with a Thumb-style IT block.
// Build option: define COND_IT_EN to compile in the IT block logic. Without
// it the IT inputs are ignored, InIT is 0 and Cond alone is evaluated.
module condlogic_pred #(
  parameter int CTRL_W = 3,
  parameter int IT_MAX = 4,
  parameter int LEN_W  = $clog2(IT_MAX + 1)
) (
  input logic             clk,
  input logic             reset,
  condlogic_pred_if.slave bus
);

  // ARM condition table evaluated against the architectural flags.
  function automatic logic cond_eval(input logic [3:0] flags, input logic [3:0] cond);
    logic n, z, c, v;
    logic res;
    {n, z, c, v} = flags;
    case (cond)
      4'b0000: res = z;                      // EQ
      4'b0001: res = ~z;                     // NE
      4'b0010: res = c;                      // CS
      4'b0011: res = ~c;                     // CC
      4'b0100: res = n;                      // MI
      4'b0101: res = ~n;                     // PL
      4'b0110: res = v;                      // VS
      4'b0111: res = ~v;                     // VC
      4'b1000: res = c & ~z;                 // HI
      4'b1001: res = ~c | z;                 // LS
      4'b1010: res = (n == v);               // GE
      4'b1011: res = (n != v);               // LT
      4'b1100: res = ~z & (n == v);          // GT
      4'b1101: res = z | (n != v);           // LE
      4'b1110: res = 1'b1;                   // AL
      4'b1111: res = 1'b1;                   // treated as always
      default: res = 1'b1;
    endcase
    return res;
  endfunction

  logic              advance_s;
  logic [3:0]        eff_cond_s;
  logic              cond_ex_s;
  logic              in_it_s;
  logic [3:0]        flags_r;
  logic [CTRL_W-1:0] ctrl_out_r;

  assign advance_s = bus.en & ~bus.flush;

`ifdef COND_IT_EN
  typedef enum logic [0:0] {
    IT_IDLE   = 1'b0,
    IT_ACTIVE = 1'b1
  } it_state_t;

  localparam logic [LEN_W-1:0]  LEN_ONE  = LEN_W'(1);
  localparam logic [LEN_W-1:0]  LEN_MAX  = LEN_W'(IT_MAX);
  localparam logic [IT_MAX-1:0] PAT_ONE  = IT_MAX'(1);

  it_state_t         state_r, state_nxt_s;
  logic [3:0]        base_r, base_nxt_s;
  logic [IT_MAX-1:0] pattern_r, pattern_nxt_s;
  logic [LEN_W-1:0]  remaining_r, remaining_nxt_s;

  // Effective condition: IT slot condition while a block is active, else Cond.
  always_comb begin
    eff_cond_s = bus.Cond;
    if (state_r == IT_ACTIVE) begin
      // AL has no inverse, so an else slot under base 1110 stays 1110.
      if (pattern_r[0] || (base_r == 4'b1110)) begin
        eff_cond_s = base_r;
      end else begin
        eff_cond_s = base_r ^ 4'b0001;
      end
    end else begin
      eff_cond_s = bus.Cond;
    end
  end

  // IT next-state: start, consume one slot per advance, flush abandons.
  always_comb begin
    state_nxt_s     = state_r;
    base_nxt_s      = base_r;
    pattern_nxt_s   = pattern_r;
    remaining_nxt_s = remaining_r;
    case (state_r)
      IT_IDLE: begin
        // The IT instruction itself is predicated by its own Cond.
        if (advance_s && bus.ITStart && cond_ex_s && (bus.ITLen != {LEN_W{1'b0}})) begin
          state_nxt_s     = IT_ACTIVE;
          base_nxt_s      = bus.ITCond;
          pattern_nxt_s   = bus.ITPattern | PAT_ONE;
          remaining_nxt_s = (bus.ITLen > LEN_MAX) ? LEN_MAX : bus.ITLen;
        end else begin
          state_nxt_s = IT_IDLE;
        end
      end
      IT_ACTIVE: begin
        // ITStart is ignored here; the instruction just takes its slot.
        if (advance_s) begin
          pattern_nxt_s = {1'b0, pattern_r[IT_MAX-1:1]};
          if (remaining_r <= LEN_ONE) begin
            state_nxt_s     = IT_IDLE;
            remaining_nxt_s = {LEN_W{1'b0}};
          end else begin
            remaining_nxt_s = remaining_r - LEN_ONE;
          end
        end else begin
          state_nxt_s = IT_ACTIVE;
        end
      end
      default: begin
        state_nxt_s     = IT_IDLE;
        remaining_nxt_s = {LEN_W{1'b0}};
      end
    endcase
    // A flush kills the current instruction and any block in progress.
    if (bus.flush) begin
      state_nxt_s     = IT_IDLE;
      remaining_nxt_s = {LEN_W{1'b0}};
    end else begin
      remaining_nxt_s = remaining_nxt_s;
    end
  end

  // IT state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IT_IDLE;
      base_r      <= 4'b0000;
      pattern_r   <= {IT_MAX{1'b0}};
      remaining_r <= {LEN_W{1'b0}};
    end else begin
      state_r     <= state_nxt_s;
      base_r      <= base_nxt_s;
      pattern_r   <= pattern_nxt_s;
      remaining_r <= remaining_nxt_s;
    end
  end

  assign in_it_s = (state_r == IT_ACTIVE);
`else
  logic              unused_it_s;
  logic [IT_MAX-1:0] unused_pat_s;
  logic [LEN_W-1:0]  unused_len_s;

  assign unused_pat_s = bus.ITPattern;
  assign unused_len_s = bus.ITLen;
  assign unused_it_s  = ^{bus.ITStart, bus.ITCond, unused_len_s, unused_pat_s};
  assign eff_cond_s   = bus.Cond;
  assign in_it_s      = 1'b0;
`endif

  assign cond_ex_s = cond_eval(flags_r, eff_cond_s);

  // NZCV register: two independently enabled groups, only on executed instructions.
  always_ff @(posedge clk) begin
    if (reset) begin
      flags_r <= 4'b0000;
    end else if (advance_s && cond_ex_s) begin
      if (bus.FlagW[1]) begin
        flags_r[3:2] <= bus.ALUFlags[3:2];
      end
      if (bus.FlagW[0]) begin
        flags_r[1:0] <= bus.ALUFlags[1:0];
      end
    end
  end

  // Registered control strobes: gated by CondEx, cleared on flush, held when stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_out_r <= {CTRL_W{1'b0}};
    end else if (bus.flush) begin
      ctrl_out_r <= {CTRL_W{1'b0}};
    end else if (bus.en) begin
      ctrl_out_r <= bus.Ctrl & {CTRL_W{cond_ex_s}};
    end
  end

  assign bus.CtrlOut = ctrl_out_r;
  assign bus.CondEx  = cond_ex_s;
  assign bus.Flags   = flags_r;
  assign bus.InIT    = in_it_s;

endmodule
